mc_main_controller: RTL and testbench

//  Control FSM for the multicycle MIPS datapath (regfile, ALU, muxes, PC/IR/data flops).

---
 rtl/mc_main_controller_pkg.sv | 51 +++++
 rtl/mc_main_controller_alu_decoder.sv | 30 +++
 rtl/mc_main_controller.sv | 132 +++++++++++++
 tb/tb_mc_main_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_main_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcode/funct
// constants and the aluop/alucontrol encodings used by the controller and ALU decoder.
package mc_main_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_main_controller_alu_decoder.sv
// ALU control decode: maps the FSM's aluop plus the R-type funct field to alucontrol.
module mc_alu_decoder
    import mc_main_controller_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unrecognised funct codes fall back to add rather than trapping.
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle MIPS main control FSM: Moore decode of enables/selects per state,
// with pcen additionally gated by the ALU zero flag for branches.
module mc_main_controller
    import mc_main_controller_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t state, next_state;
    aluop_t aluop;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    default:      next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = S_MEMWB;
            S_RTYPEEX: next_state = S_RTYPEWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            S_HALT:    next_state = S_HALT;
            // Terminal states of each instruction and the unused codes 13-15 all land in FETCH.
            default:   next_state = S_FETCH;
        endcase
    end

    always_comb begin
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = ~is_known_op(op);
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            S_HALT:  illegal_op = 1'b1;
            default: ;
        endcase
    end

    mc_alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    assign pcen      = pcwrite | (branch & zero);
    assign state_dbg = state;

endmodule

// File: tb/tb_mc_main_controller.sv
// Directed bench for mc_main_controller: a per-cycle vector table for every instruction
// class plus hand-written reset and halt sequences.
module tb_mc_main_controller;

    logic       clk = 1'b0;
    logic       reset0, reset1;
    logic [5:0] op, funct;
    logic       zero;

    logic       pcen0, iord0, irwrite0, memwrite0, regwrite0, regdst0, memtoreg0, alusrca0, ill0;
    logic [1:0] alusrcb0, pcsrc0;
    logic [2:0] aluctl0;
    logic [3:0] st0;

    logic       pcen1, iord1, irwrite1, memwrite1, regwrite1, regdst1, memtoreg1, alusrca1, ill1;
    logic [1:0] alusrcb1, pcsrc1;
    logic [2:0] aluctl1;
    logic [3:0] st1;

    always #5 clk = ~clk;

    mc_main_controller #(.ILLEGAL_HALT(1'b0)) dut0 (
        .clk(clk), .reset(reset0), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen0), .iord(iord0), .irwrite(irwrite0), .memwrite(memwrite0),
        .regwrite(regwrite0), .regdst(regdst0), .memtoreg(memtoreg0), .alusrca(alusrca0),
        .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(aluctl0), .illegal_op(ill0),
        .state_dbg(st0)
    );

    mc_main_controller #(.ILLEGAL_HALT(1'b1)) dut1 (
        .clk(clk), .reset(reset1), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen1), .iord(iord1), .irwrite(irwrite1), .memwrite(memwrite1),
        .regwrite(regwrite1), .regdst(regdst1), .memtoreg(memtoreg1), .alusrca(alusrca1),
        .alusrcb(alusrcb1), .pcsrc(pcsrc1), .alucontrol(aluctl1), .illegal_op(ill1),
        .state_dbg(st1)
    );

    // Output pack: {pcen,iord,irwrite,memwrite,regwrite,regdst,memtoreg,alusrca, alusrcb, pcsrc, alucontrol, illegal_op}
    wire [15:0] outs0 = {pcen0, iord0, irwrite0, memwrite0, regwrite0, regdst0, memtoreg0, alusrca0,
                         alusrcb0, pcsrc0, aluctl0, ill0};
    wire [15:0] outs1 = {pcen1, iord1, irwrite1, memwrite1, regwrite1, regdst1, memtoreg1, alusrca1,
                         alusrcb1, pcsrc1, aluctl1, ill1};

    localparam logic [15:0] O_FETCH   = {8'b1010_0000, 2'b01, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] O_DEC     = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] O_DEC_ILL = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1};
    localparam logic [15:0] O_MEMADR  = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] O_MEMRD   = {8'b0100_0000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] O_MEMWB   = {8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] O_MEMWR   = {8'b0101_0000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] O_RT_ADD  = {8'b0000_0001, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] O_RT_SUB  = {8'b0000_0001, 2'b00, 2'b00, 3'b110, 1'b0};
    localparam logic [15:0] O_RT_AND  = {8'b0000_0001, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] O_RT_OR   = {8'b0000_0001, 2'b00, 2'b00, 3'b001, 1'b0};
    localparam logic [15:0] O_RT_SLT  = {8'b0000_0001, 2'b00, 2'b00, 3'b111, 1'b0};
    localparam logic [15:0] O_RTWB    = {8'b0000_1100, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] O_ADDIWB  = {8'b0000_1000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] O_BEQ_T   = {8'b1000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
    localparam logic [15:0] O_BEQ_NT  = {8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
    localparam logic [15:0] O_JEX     = {8'b1000_0000, 2'b00, 2'b10, 3'b010, 1'b0};
    localparam logic [15:0] O_HALT    = {8'b0000_0000, 2'b00, 2'b00, 3'b010, 1'b1};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [15:0] outs;
    } vec_t;

    vec_t tv[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic [3:0] s, input logic [15:0] e);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.st = s; v.outs = e;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        reset0 = 1'b1;
        reset1 = 1'b1;
        op     = 6'b100011;
        funct  = 6'b000000;
        zero   = 1'b0;

        // lw: 0,1,2,3,4
        add(6'b100011, 6'd0, 1'b0, 4'd0, O_FETCH);
        add(6'b100011, 6'd0, 1'b0, 4'd1, O_DEC);
        add(6'b100011, 6'd0, 1'b0, 4'd2, O_MEMADR);
        add(6'b100011, 6'd0, 1'b0, 4'd3, O_MEMRD);
        add(6'b100011, 6'd0, 1'b0, 4'd4, O_MEMWB);
        // sw: 0,1,2,5
        add(6'b101011, 6'd0, 1'b0, 4'd0, O_FETCH);
        add(6'b101011, 6'd0, 1'b0, 4'd1, O_DEC);
        add(6'b101011, 6'd0, 1'b0, 4'd2, O_MEMADR);
        add(6'b101011, 6'd0, 1'b0, 4'd5, O_MEMWR);
        // R-type with several funct codes, including an unknown one that decodes as add
        add(6'b000000, 6'b100010, 1'b0, 4'd0, O_FETCH);
        add(6'b000000, 6'b100010, 1'b0, 4'd1, O_DEC);
        add(6'b000000, 6'b100010, 1'b0, 4'd6, O_RT_SUB);
        add(6'b000000, 6'b100010, 1'b0, 4'd7, O_RTWB);
        add(6'b000000, 6'b100100, 1'b0, 4'd0, O_FETCH);
        add(6'b000000, 6'b100100, 1'b0, 4'd1, O_DEC);
        add(6'b000000, 6'b100100, 1'b0, 4'd6, O_RT_AND);
        add(6'b000000, 6'b100100, 1'b0, 4'd7, O_RTWB);
        add(6'b000000, 6'b101010, 1'b0, 4'd0, O_FETCH);
        add(6'b000000, 6'b101010, 1'b0, 4'd1, O_DEC);
        add(6'b000000, 6'b101010, 1'b0, 4'd6, O_RT_SLT);
        add(6'b000000, 6'b101010, 1'b0, 4'd7, O_RTWB);
        add(6'b000000, 6'b100101, 1'b0, 4'd0, O_FETCH);
        add(6'b000000, 6'b100101, 1'b0, 4'd1, O_DEC);
        add(6'b000000, 6'b100101, 1'b0, 4'd6, O_RT_OR);
        add(6'b000000, 6'b100101, 1'b0, 4'd7, O_RTWB);
        add(6'b000000, 6'b111111, 1'b0, 4'd0, O_FETCH);
        add(6'b000000, 6'b111111, 1'b0, 4'd1, O_DEC);
        add(6'b000000, 6'b111111, 1'b0, 4'd6, O_RT_ADD);
        add(6'b000000, 6'b111111, 1'b0, 4'd7, O_RTWB);
        // addi: 0,1,9,10
        add(6'b001000, 6'd0, 1'b0, 4'd0, O_FETCH);
        add(6'b001000, 6'd0, 1'b0, 4'd1, O_DEC);
        add(6'b001000, 6'd0, 1'b0, 4'd9, O_MEMADR);
        add(6'b001000, 6'd0, 1'b0, 4'd10, O_ADDIWB);
        // beq taken: zero high in DECODE too, where pcen must stay low
        add(6'b000100, 6'd0, 1'b1, 4'd0, O_FETCH);
        add(6'b000100, 6'd0, 1'b1, 4'd1, O_DEC);
        add(6'b000100, 6'd0, 1'b1, 4'd8, O_BEQ_T);
        // beq not taken
        add(6'b000100, 6'd0, 1'b0, 4'd0, O_FETCH);
        add(6'b000100, 6'd0, 1'b0, 4'd1, O_DEC);
        add(6'b000100, 6'd0, 1'b0, 4'd8, O_BEQ_NT);
        // j: 0,1,11
        add(6'b000010, 6'd0, 1'b0, 4'd0, O_FETCH);
        add(6'b000010, 6'd0, 1'b0, 4'd1, O_DEC);
        add(6'b000010, 6'd0, 1'b0, 4'd11, O_JEX);
        // illegal opcode without halt: one DECODE cycle with illegal_op, then FETCH
        add(6'b111111, 6'd0, 1'b0, 4'd0, O_FETCH);
        add(6'b111111, 6'd0, 1'b0, 4'd1, O_DEC_ILL);
        add(6'b100011, 6'd0, 1'b0, 4'd0, O_FETCH);

        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'(st0), 32'd0);
        check("reset_outs", 32'(outs0), 32'(O_FETCH));

        // Table: one row per clock cycle, sampled mid-cycle after inputs settle
        reset0 = 1'b0;
        for (int i = 0; i < tv.size(); i++) begin
            op = tv[i].op; funct = tv[i].funct; zero = tv[i].zero;
            #1;
            check($sformatf("vec%0d_state", i), 32'(st0), 32'(tv[i].st));
            check($sformatf("vec%0d_outs", i), 32'(outs0), 32'(tv[i].outs));
            @(negedge clk);
        end

        // Async reset in the middle of lw (state MEMRD)
        op = 6'b100011; funct = 6'd0; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("midlw_pre_state", 32'(st0), 32'd3);
        reset0 = 1'b1;
        #1;
        check("midlw_async_state", 32'(st0), 32'd0);
        check("midlw_async_outs", 32'(outs0), 32'(O_FETCH));
        @(negedge clk);
        #1;
        check("midlw_held_state", 32'(st0), 32'd0);
        reset0 = 1'b0;
        @(negedge clk);
        #1;
        check("midlw_refetch_state", 32'(st0), 32'd1);
        @(negedge clk);
        #1;
        check("midlw_memadr_state", 32'(st0), 32'd2);

        // Halting variant: illegal opcode parks in HALT until reset
        @(negedge clk);
        op = 6'b111111; zero = 1'b0;
        reset1 = 1'b0;
        #1;
        check("halt_fetch_state", 32'(st1), 32'd0);
        @(negedge clk);
        #1;
        check("halt_decode_outs", 32'(outs1), 32'(O_DEC_ILL));
        @(negedge clk);
        #1;
        check("halt_enter_state", 32'(st1), 32'd12);
        check("halt_enter_outs", 32'(outs1), 32'(O_HALT));
        op = 6'b100011; zero = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("halt_stay_state", 32'(st1), 32'd12);
        check("halt_stay_outs", 32'(outs1), 32'(O_HALT));
        reset1 = 1'b1;
        #1;
        check("halt_reset_state", 32'(st1), 32'd0);
        @(negedge clk);
        reset1 = 1'b0;
        op = 6'b000010; zero = 1'b0;
        @(negedge clk);
        #1;
        check("halt_restart_state", 32'(st1), 32'd1);
        @(negedge clk);
        #1;
        check("halt_restart_jex", 32'(outs1), 32'(O_JEX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
